// File: rtl/comm_pkg.sv
// comm_pkg: shared types and defaults for the communication_send/communication_receive pair.
package comm_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_END} comm_rx_state_t;

   localparam int COMM_DATA_W      = 8;
   localparam int COMM_SYNC_STAGES = 2;

endpackage

// File: rtl/comm_sync.sv
// comm_sync: N-stage flip-flop synchroniser for a single asynchronous bit.
module comm_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [N-1:0] r;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r <= '0;
      else        r <= {r[N-2:0], d};

   assign q = r[N-1];

endmodule

// File: rtl/communication_receive.sv
// communication_receive: serial MSB-first frame receiver with level acknowledge.
// Define COMM_RX_PARITY_EN to expect a trailing even-parity bit after the data.
module communication_receive
   import comm_pkg::*;
#(
   parameter int DATA_W      = COMM_DATA_W,
   parameter int SYNC_STAGES = COMM_SYNC_STAGES
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              sd,
   input  logic              freq,
   input  logic              rec_en,
   output logic [DATA_W-1:0] rec_data,
   output logic              rec_valid,
   output logic              finish_rec,
   output logic              frame_err,
   output logic              parity_err
);

`ifdef COMM_RX_PARITY_EN
   localparam int FRAME_BITS = DATA_W + 1;
`else
   localparam int FRAME_BITS = DATA_W;
`endif
   localparam int CW = $clog2(DATA_W + 2);

   comm_rx_state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [FRAME_BITS-1:0] shreg, shreg_nx;
   logic sd_s, freq_s, en_s, freq_q, freq_rise, abort, load, ok;

   comm_sync #(.N(SYNC_STAGES)) u_sd   (.clk(clk1), .rst_n(rst_n), .d(sd),     .q(sd_s));
   comm_sync #(.N(SYNC_STAGES)) u_freq (.clk(clk1), .rst_n(rst_n), .d(freq),   .q(freq_s));
   comm_sync #(.N(SYNC_STAGES)) u_en   (.clk(clk1), .rst_n(rst_n), .d(rec_en), .q(en_s));

   assign freq_rise = freq_s & ~freq_q;

   // An enable drop takes priority over a coincident bit strobe.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      shreg_nx = shreg;
      abort    = 1'b0;
      case (state)
         IDLE: if (en_s) begin
            state_nx = SHIFT;
            cnt_nx   = '0;
            shreg_nx = '0;
         end
         SHIFT: if (!en_s) begin
            state_nx = IDLE;
            abort    = 1'b1;
         end else if (freq_rise) begin
            shreg_nx = {shreg[FRAME_BITS-2:0], sd_s};
            cnt_nx   = cnt + 1'b1;
            if (cnt_nx == CW'(FRAME_BITS)) state_nx = DONE;
         end
         DONE:    state_nx = WAIT_END;
         default: if (!en_s) state_nx = IDLE;
      endcase
   end

   // Outputs are registered on the transition so they line up with the DONE cycle.
   assign load = (state == SHIFT) && (state_nx == DONE);

`ifdef COMM_RX_PARITY_EN
   assign ok = ~^shreg_nx;

   always_ff @(posedge clk1 or negedge rst_n)
      if (!rst_n) parity_err <= 1'b0;
      else        parity_err <= load & ~ok;
`else
   assign ok         = 1'b1;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk1 or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         shreg      <= '0;
         freq_q     <= 1'b0;
         rec_data   <= '0;
         rec_valid  <= 1'b0;
         finish_rec <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         shreg      <= shreg_nx;
         freq_q     <= freq_s;
         rec_valid  <= load & ok;
         if (load & ok) rec_data <= shreg_nx[FRAME_BITS-1 -: DATA_W];
         finish_rec <= (state_nx == DONE) || (state_nx == WAIT_END);
         frame_err  <= abort;
      end

endmodule

// File: tb/tb_communication_receive.sv
// tb_communication_receive: directed-vector bench for communication_receive.
`timescale 1ms/1us
module tb_communication_receive;

`ifdef COMM_RX_PARITY_EN
   localparam int FB = 9;
`else
   localparam int FB = 8;
`endif

   logic clk1 = 1'b0, rst_n = 1'b0, sd = 1'b0, freq = 1'b0, rec_en = 1'b0;
   logic [7:0] rec_data;
   logic rec_valid, finish_rec, frame_err, parity_err;
   int n_cmp = 0, n_bad = 0, n_val = 0, n_ferr = 0, n_perr = 0;
   logic [7:0] vq[$];
   logic [7:0] exp_last;

   always #10 clk1 = ~clk1;

   communication_receive dut (
      .clk1(clk1), .rst_n(rst_n), .sd(sd), .freq(freq), .rec_en(rec_en),
      .rec_data(rec_data), .rec_valid(rec_valid), .finish_rec(finish_rec),
      .frame_err(frame_err), .parity_err(parity_err)
   );

   always @(negedge clk1) begin
      if (rec_valid === 1'b1) begin
         n_val++;
         vq.push_back(rec_data);
      end
      if (frame_err === 1'b1) n_ferr++;
      if (parity_err === 1'b1) n_perr++;
   end

   function automatic logic [FB-1:0] fbits(input logic [7:0] w, input logic flip);
      logic [8:0] f;
      f = {w, ^w ^ flip};
      return f[8 -: FB];
   endfunction

   task automatic send_bit(input logic b);
      freq = 1'b0;
      sd = b;
      repeat (8) @(negedge clk1);
      freq = 1'b1;
      repeat (8) @(negedge clk1);
   endtask

   task automatic send_bits(input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic start_frame();
      rec_en = 1'b1;
      repeat (4) @(negedge clk1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk1);
      n_cmp += 5;
      if (rec_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", rec_data); end
      if (rec_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", rec_valid); end
      if (finish_rec !== 1'b0) begin n_bad++; $display("FAIL reset_finish got %b want 0", finish_rec); end
      if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr got %b want 0", frame_err); end
      if (parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_perr got %b want 0", parity_err); end
      rst_n = 1'b1;
      repeat (4) @(negedge clk1);
   endtask

   task automatic test_single();
      logic [FB-1:0] f;
      int v0, e0;
      f = fbits(8'hAE, 1'b0);
      v0 = n_val;
      e0 = n_ferr;
      start_frame();
      send_bits(16'(f >> 1), FB - 1);
      freq = 1'b0;
      sd = f[0];
      repeat (8) @(negedge clk1);
      freq = 1'b1;
      repeat (2) @(negedge clk1);
      n_cmp++;
      if (rec_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid got %b want 0", rec_valid); end
      @(negedge clk1);
      n_cmp += 3;
      if (rec_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b want 1", rec_valid); end
      if (rec_data !== 8'hAE) begin n_bad++; $display("FAIL single_data got %h want ae", rec_data); end
      if (finish_rec !== 1'b1) begin n_bad++; $display("FAIL single_finish_rise got %b want 1", finish_rec); end
      @(negedge clk1);
      n_cmp++;
      if (rec_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_width got %b want 0", rec_valid); end
      repeat (4) @(negedge clk1);
      rec_en = 1'b0;
      repeat (2) @(negedge clk1);
      n_cmp++;
      if (finish_rec !== 1'b1) begin n_bad++; $display("FAIL single_finish_hold got %b want 1", finish_rec); end
      @(negedge clk1);
      n_cmp++;
      if (finish_rec !== 1'b0) begin n_bad++; $display("FAIL single_finish_fall got %b want 0", finish_rec); end
      repeat (6) @(negedge clk1);
      n_cmp += 2;
      if (n_val - v0 !== 1) begin n_bad++; $display("FAIL single_valid_count got %0d want 1", n_val - v0); end
      if (n_ferr - e0 !== 0) begin n_bad++; $display("FAIL single_ferr_count got %0d want 0", n_ferr - e0); end
   endtask

   task automatic test_back_to_back();
      int b;
      b = vq.size();
      start_frame();
      send_bits(16'(fbits(8'hAE, 1'b0)), FB);
      rec_en = 1'b0;
      repeat (4) @(negedge clk1);
      start_frame();
      send_bits(16'(fbits(8'h51, 1'b0)), FB);
      rec_en = 1'b0;
      repeat (6) @(negedge clk1);
      n_cmp++;
      if (vq.size() - b !== 2) begin
         n_bad++;
         $display("FAIL b2b_count got %0d want 2", vq.size() - b);
      end else begin
         n_cmp += 2;
         if (vq[b] !== 8'hAE) begin n_bad++; $display("FAIL b2b_first got %h want ae", vq[b]); end
         if (vq[b+1] !== 8'h51) begin n_bad++; $display("FAIL b2b_second got %h want 51", vq[b+1]); end
      end
      n_cmp++;
      if (rec_data !== 8'h51) begin n_bad++; $display("FAIL b2b_data got %h want 51", rec_data); end
      exp_last = 8'h51;
   endtask

`ifdef COMM_RX_PARITY_EN
   task automatic test_parity();
      int v0, p0;
      v0 = n_val;
      p0 = n_perr;
      start_frame();
      send_bits(16'(fbits(8'hAE, 1'b1)), FB);
      n_cmp += 4;
      if (finish_rec !== 1'b1) begin n_bad++; $display("FAIL parity_bad_finish got %b want 1", finish_rec); end
      if (n_perr - p0 !== 1) begin n_bad++; $display("FAIL parity_bad_perr got %0d want 1", n_perr - p0); end
      if (n_val - v0 !== 0) begin n_bad++; $display("FAIL parity_bad_valid got %0d want 0", n_val - v0); end
      if (rec_data !== 8'h51) begin n_bad++; $display("FAIL parity_bad_data got %h want 51", rec_data); end
      rec_en = 1'b0;
      repeat (6) @(negedge clk1);
      start_frame();
      send_bits(16'(fbits(8'hAE, 1'b0)), FB);
      rec_en = 1'b0;
      repeat (6) @(negedge clk1);
      n_cmp += 3;
      if (n_val - v0 !== 1) begin n_bad++; $display("FAIL parity_good_valid got %0d want 1", n_val - v0); end
      if (n_perr - p0 !== 1) begin n_bad++; $display("FAIL parity_good_perr got %0d want 1", n_perr - p0); end
      if (rec_data !== 8'hAE) begin n_bad++; $display("FAIL parity_good_data got %h want ae", rec_data); end
      exp_last = 8'hAE;
   endtask
`endif

   task automatic test_abort();
      int v0, e0;
      v0 = n_val;
      e0 = n_ferr;
      start_frame();
      send_bits(16'(fbits(8'h3C, 1'b0) >> (FB - 5)), 5);
      rec_en = 1'b0;
      repeat (8) @(negedge clk1);
      n_cmp += 4;
      if (n_ferr - e0 !== 1) begin n_bad++; $display("FAIL abort_ferr got %0d want 1", n_ferr - e0); end
      if (n_val - v0 !== 0) begin n_bad++; $display("FAIL abort_valid got %0d want 0", n_val - v0); end
      if (rec_data !== exp_last) begin n_bad++; $display("FAIL abort_data got %h want %h", rec_data, exp_last); end
      if (finish_rec !== 1'b0) begin n_bad++; $display("FAIL abort_finish got %b want 0", finish_rec); end
   endtask

   task automatic test_reset_mid();
      int v0, e0;
      e0 = n_ferr;
      start_frame();
      send_bits(16'h0005, 3);
      rst_n = 1'b0;
      rec_en = 1'b0;
      freq = 1'b0;
      @(negedge clk1);
      n_cmp += 4;
      if (rec_data !== 8'h00) begin n_bad++; $display("FAIL midrst_data got %h want 00", rec_data); end
      if (rec_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", rec_valid); end
      if (finish_rec !== 1'b0) begin n_bad++; $display("FAIL midrst_finish got %b want 0", finish_rec); end
      if (frame_err !== 1'b0) begin n_bad++; $display("FAIL midrst_ferr got %b want 0", frame_err); end
      repeat (3) @(negedge clk1);
      rst_n = 1'b1;
      repeat (4) @(negedge clk1);
      v0 = n_val;
      start_frame();
      send_bits(16'(fbits(8'h3C, 1'b0)), FB);
      rec_en = 1'b0;
      repeat (6) @(negedge clk1);
      n_cmp += 3;
      if (rec_data !== 8'h3C) begin n_bad++; $display("FAIL midrst_after_data got %h want 3c", rec_data); end
      if (n_val - v0 !== 1) begin n_bad++; $display("FAIL midrst_after_valid got %0d want 1", n_val - v0); end
      if (n_ferr - e0 !== 0) begin n_bad++; $display("FAIL midrst_no_ferr got %0d want 0", n_ferr - e0); end
   endtask

   task automatic test_extra_edges();
      int v0, e0;
      v0 = n_val;
      e0 = n_ferr;
      start_frame();
      send_bits(16'(fbits(8'hAE, 1'b0)), FB);
      send_bits(16'hFFFF, 12 - FB);
      n_cmp += 4;
      if (finish_rec !== 1'b1) begin n_bad++; $display("FAIL extra_finish got %b want 1", finish_rec); end
      if (n_val - v0 !== 1) begin n_bad++; $display("FAIL extra_valid got %0d want 1", n_val - v0); end
      if (rec_data !== 8'hAE) begin n_bad++; $display("FAIL extra_data got %h want ae", rec_data); end
      if (n_ferr - e0 !== 0) begin n_bad++; $display("FAIL extra_ferr got %0d want 0", n_ferr - e0); end
      rec_en = 1'b0;
      repeat (6) @(negedge clk1);
      n_cmp++;
      if (finish_rec !== 1'b0) begin n_bad++; $display("FAIL extra_finish_fall got %b want 0", finish_rec); end
   endtask

   initial begin
      exp_last = 8'h00;
      test_reset();
      test_single();
      test_back_to_back();
`ifdef COMM_RX_PARITY_EN
      test_parity();
`endif
      test_abort();
      test_reset_mid();
      test_extra_edges();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
